regfile_param: RTL and testbench

Parametrised general-purpose register file for the MIPS datapath, replacing the fixed 32×32 array. Provides two asynchronous read ports and one synchronous write port. Contents are cleared by a hardware sweep after reset, with a `ready` flag gating use. An optional write-to-read bypass lets a same-cycle write be seen by the decode stage.

---
 rtl/regfile_param_if.sv | 29 ++
 rtl/regfile_param.sv | 101 ++++++++++
 tb/tb_regfile_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// regfile_param_if: bus bundle between the datapath and the register file.
//   regWrite, writeRegister, writeData : write port (sampled on rising clk)
//   readRegister1/2                    : read addresses (Rs / Rt)
//   readData1/2                        : combinational read data
//   ready                              : high once the post-reset clear sweep is done
// Modports: master = datapath side, slave = register file side.
interface regfile_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  ready;

  modport master (
    output regWrite, writeRegister, writeData, readRegister1, readRegister2,
    input  readData1, readData2, ready
  );

  modport slave (
    input  regWrite, writeRegister, writeData, readRegister1, readRegister2,
    output readData1, readData2, ready
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised MIPS general-purpose register file.
//   Two combinational read ports, one synchronous write port, hardware clear
//   sweep after reset (one entry per cycle) with a ready flag gating use.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, restarts the clear sweep
//   bus : regfile_param_if.slave (write port, two read ports, ready)
// Parameters: DATA_WIDTH, ADDR_WIDTH (depth = 2**ADDR_WIDTH), ZERO_REG
//   (1 = entry 0 reads as zero and ignores writes).
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to
//   any read port addressing the written entry.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input logic             clk,
  input logic             rst,
  regfile_param_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam bit ZeroReg = (ZERO_REG != 0);
  localparam logic [ADDR_WIDTH-1:0] LastPtr = {ADDR_WIDTH{1'b1}};

  typedef enum logic {StClear, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_hit;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  // A write that will actually land in the array this cycle.
  assign wr_hit = (state_q == StRun) && bus.regWrite &&
                  !(ZeroReg && (bus.writeRegister == '0));

  assign ready = (state_q == StRun);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LastPtr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we    = wr_hit;
        mem_waddr = bus.writeRegister;
        mem_wdata = bus.writeData;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array is not reset directly; the sweep clears it. Reset blocks any write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd1 = mem_q[bus.readRegister1];
    rd2 = mem_q[bus.readRegister2];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (bus.readRegister1 == bus.writeRegister)) rd1 = bus.writeData;
    if (wr_hit && (bus.readRegister2 == bus.writeRegister)) rd2 = bus.writeData;
`endif
    if (!ready || (ZeroReg && (bus.readRegister1 == '0))) rd1 = '0;
    if (!ready || (ZeroReg && (bus.readRegister2 == '0))) rd2 = '0;
  end

  assign bus.readData1 = rd1;
  assign bus.readData2 = rd2;
  assign bus.ready     = ready;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; dut_a (ZERO_REG=1) and dut_b (ZERO_REG=0) see the same bus.
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;

  int checks = 0;
  int errors = 0;

  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();
  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus_c ();

  assign bus_a.regWrite = we;       assign bus_b.regWrite = we;
  assign bus_a.writeRegister = wa;  assign bus_b.writeRegister = wa;
  assign bus_a.writeData = wd;      assign bus_b.writeData = wd;
  assign bus_a.readRegister1 = ra1; assign bus_b.readRegister1 = ra1;
  assign bus_a.readRegister2 = ra2; assign bus_b.readRegister2 = ra2;
  assign bus_c.regWrite = 1'b0;
  assign bus_c.writeRegister = wa[2:0];
  assign bus_c.writeData = wd;
  assign bus_c.readRegister1 = ra1[2:0];
  assign bus_c.readRegister2 = ra2[2:0];

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave));

  // Reference model: contents after the sweep plus a count of edges since reset.
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  int unsigned cnt = 0, cnt_c = 0;
  bit          m_ready = 1'b0, m_ready_c = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      cnt = 0; m_ready = 1'b0; cnt_c = 0; m_ready_c = 1'b0;
    end else begin
      if (!m_ready) begin
        cnt++;
        if (cnt == 32) begin
          m_ready = 1'b1;
          for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
          end
        end
      end else if (we) begin
        if (wa != 0) mem_a[wa] = wd;
        mem_b[wa] = wd;
      end
      if (!m_ready_c) begin
        cnt_c++;
        if (cnt_c == 8) m_ready_c = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(bit zr, logic [4:0] ra);
    if (!m_ready) return '0;
    if (zr && ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && ra == wa && !(zr && wa == 0)) return wd;
`endif
    return zr ? mem_a[ra] : mem_b[ra];
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk("ready_a", {31'd0, bus_a.ready}, {31'd0, m_ready});
    chk("ready_b", {31'd0, bus_b.ready}, {31'd0, m_ready});
    chk("ready_c", {31'd0, bus_c.ready}, {31'd0, m_ready_c});
    chk("rd1_a", bus_a.readData1, exp_rd(1'b1, ra1));
    chk("rd2_a", bus_a.readData2, exp_rd(1'b1, ra2));
    chk("rd1_b", bus_b.readData1, exp_rd(1'b0, ra1));
    chk("rd2_b", bus_b.readData2, exp_rd(1'b0, ra2));
    if (m_ready_c) begin
      chk("rd1_c", bus_c.readData1, 32'd0);
    end
  endtask

  task automatic cycle();
    check_all();
    tick();
  endtask

  task automatic write(logic [4:0] a, logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    cycle();
    we = 1'b0;
  endtask

  // Count edges until ready rises; a missing rise counts as a failure.
  task automatic sweep(int exp_edges);
    int edges = 0;
    while (!bus_a.ready && edges < 40) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      cycle();
      edges++;
    end
    chk("sweep_edges", 32'(edges), 32'(exp_edges));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    // Reset sweep: ready low for 31 edges, high on the 32nd; dut_c after 8.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep(32);
    chk("ready_after_sweep", {31'd0, bus_a.ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      check_all();
      chk("swept_zero", bus_b.readData1, 32'd0);
    end

    // Reset mid-sweep with an ignored write to reg 7.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      we = (i > 4); wa = 5'd7; wd = 32'hDEADBEEF;
      cycle();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    cycle();
    we = 1'b0;
    sweep(31);
    ra1 = 5'd7; ra2 = 5'd7;
    check_all();
    chk("reg7_not_stored", bus_b.readData1, 32'd0);

    // Basic write/read.
    write(5'd8, 32'h12345678);
    write(5'd31, 32'hA5A5A5A5);
    ra1 = 5'd8; ra2 = 5'd31;
    check_all();
    chk("reg8_p1", bus_a.readData1, 32'h12345678);
    chk("reg31_p2", bus_a.readData2, 32'hA5A5A5A5);
    ra2 = 5'd8;
    check_all();
    chk("reg8_p2", bus_a.readData2, 32'h12345678);

    // Zero register.
    write(5'd0, 32'hFFFFFFFF);
    ra1 = 5'd0; ra2 = 5'd0;
    check_all();
    chk("zr1_reads_zero", bus_a.readData1, 32'd0);
    chk("zr0_reads_back", bus_b.readData2, 32'hFFFFFFFF);

    // Same-cycle hazard on reg 9.
    write(5'd9, 32'h8);
    ra1 = 5'd9;
    we = 1'b1; wa = 5'd9; wd = 32'h55;
    check_all();
`ifdef REGFILE_BYPASS_EN
    chk("hazard_same_cycle", bus_a.readData1, 32'h55);
`else
    chk("hazard_same_cycle", bus_a.readData1, 32'h8);
`endif
    tick();
    we = 1'b0;
    check_all();
    chk("hazard_next_cycle", bus_a.readData1, 32'h55);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      we  = 1'($urandom);
      wa  = 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      cycle();
    end
    we = 1'b0;

    // Reset and write together: reset wins.
    write(5'd4, 32'h77);
    rst = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h1;
    tick();
    rst = 1'b0; we = 1'b0;
    sweep(32);
    ra1 = 5'd4; ra2 = 5'd4;
    check_all();
    chk("collision_reg4", bus_b.readData1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
